// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - steps simple_calc through enabled opcodes and stores each result
module calc_op_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] OP_MASK       = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] SW_X,
  input  logic [3:0] SW_Y,
  input  logic [1:0] rd_sel,
  output logic [3:0] CALC_X,
  output logic [3:0] CALC_Y,
  output logic [1:0] CALC_op_sel,
  input  logic [7:0] CALC_result,
  input  logic       CALC_carry_out,
  input  logic       CALC_overflow,
  output logic [7:0] LED_output_result,
  output logic       LED_carry_out,
  output logic       LED_overflow,
  output logic [3:0] result_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      x_q, x_d, y_q, y_d;
  logic [1:0]      op_q, op_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0][9:0] ent_q, ent_d;
  logic [3:0]      above_mask;

  // Enabled opcodes strictly above the current one; 2<<3 wraps to 0 so op 3 has none.
  always_comb begin
    above_mask = OP_MASK & ~((4'd2 << op_q) - 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      valid_q <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    valid_d = valid_q;
    ent_d   = ent_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          x_d     = SW_X;
          y_d     = SW_Y;
          valid_d = '0;
          if (OP_MASK != 4'd0) begin
            op_d    = lowest_bit(OP_MASK);
            cnt_d   = '0;
            state_d = S_DRIVE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        ent_d[op_q]   = {CALC_result, CALC_carry_out, CALC_overflow};
        valid_d[op_q] = 1'b1;
        if (above_mask != 4'd0) begin
          op_d    = lowest_bit(above_mask);
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign CALC_X       = x_q;
  assign CALC_Y       = y_q;
  assign CALC_op_sel  = op_q;
  assign result_valid = valid_q;
  assign {LED_output_result, LED_carry_out, LED_overflow} = ent_q[rd_sel];

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - directed bench: default, sparse-mask and empty-mask instances
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_x = '0, sw_y = '0;
  logic [1:0] rd_sel = '0;
  logic       start_d = 1'b0, start_s = 1'b0, start_e = 1'b0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  logic [3:0] d_x, d_y, s_x, s_y, e_x, e_y;
  logic [1:0] d_op, s_op, e_op;
  logic [7:0] d_res, s_res, e_res, d_led, s_led, e_led;
  logic       d_lc, d_lo, s_lc, s_lo, e_lc, e_lo;
  logic [3:0] d_val, s_val, e_val;
  logic       d_busy, d_done, s_busy, s_done, e_busy, e_done;

  assign d_res = {d_op, 2'b00, d_x ^ d_y};
  assign s_res = {s_op, 2'b00, s_x ^ s_y};
  assign e_res = {e_op, 2'b00, e_x ^ e_y};

  calc_op_sequencer u_def (
    .clk(clk), .rst(rst), .start(start_d), .SW_X(sw_x), .SW_Y(sw_y), .rd_sel(rd_sel),
    .CALC_X(d_x), .CALC_Y(d_y), .CALC_op_sel(d_op), .CALC_result(d_res),
    .CALC_carry_out(d_op[0]), .CALC_overflow(d_op[1]),
    .LED_output_result(d_led), .LED_carry_out(d_lc), .LED_overflow(d_lo),
    .result_valid(d_val), .busy(d_busy), .done(d_done));

  calc_op_sequencer #(.SETTLE_CYCLES(3), .OP_MASK(4'b1010)) u_sp (
    .clk(clk), .rst(rst), .start(start_s), .SW_X(sw_x), .SW_Y(sw_y), .rd_sel(rd_sel),
    .CALC_X(s_x), .CALC_Y(s_y), .CALC_op_sel(s_op), .CALC_result(s_res),
    .CALC_carry_out(s_op[0]), .CALC_overflow(s_op[1]),
    .LED_output_result(s_led), .LED_carry_out(s_lc), .LED_overflow(s_lo),
    .result_valid(s_val), .busy(s_busy), .done(s_done));

  calc_op_sequencer #(.OP_MASK(4'b0000)) u_em (
    .clk(clk), .rst(rst), .start(start_e), .SW_X(sw_x), .SW_Y(sw_y), .rd_sel(rd_sel),
    .CALC_X(e_x), .CALC_Y(e_y), .CALC_op_sel(e_op), .CALC_result(e_res),
    .CALC_carry_out(e_op[0]), .CALC_overflow(e_op[1]),
    .LED_output_result(e_led), .LED_carry_out(e_lc), .LED_overflow(e_lo),
    .result_valid(e_val), .busy(e_busy), .done(e_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_def_outs", {d_x, d_y, d_op, d_led, d_lc, d_lo, d_val, d_busy, d_done}, 32'd0);
    chk("rst_sp_outs",  {s_x, s_y, s_op, s_led, s_lc, s_lo, s_val, s_busy, s_done}, 32'd0);
    chk("rst_em_outs",  {e_x, e_y, e_op, e_led, e_lc, e_lo, e_val, e_busy, e_done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy_done", {d_busy, d_done}, 32'd0);

    // Full sequence, defaults
    sw_x = 4'b1001; sw_y = 4'b0101; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("full_accept", {d_busy, d_x, d_y, d_op}, {23'd0, 1'b1, 4'b1001, 4'b0101, 2'd0});
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("full_done_e%0d", n), d_done, (n == 12));
      if (n < 12) chk($sformatf("full_op_e%0d", n), d_op, n / 3);
    end
    chk("full_valid", d_val, 4'b1111);
    rd_sel = 2'd2; #1;
    chk("full_rd2", {d_led, d_lc, d_lo}, {8'h8C, 1'b0, 1'b1});
    rd_sel = 2'd1; #1;
    chk("full_rd1", {d_led, d_lc, d_lo}, {8'h4C, 1'b1, 1'b0});
    tick();
    chk("full_idle", {d_busy, d_done}, 32'd0);

    // Sparse mask
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("sp_op_e0", s_op, 32'd1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk($sformatf("sp_done_e%0d", n), s_done, (n == 8));
      if (n < 8) chk($sformatf("sp_op_e%0d", n), s_op, (n < 4) ? 1 : 3);
    end
    chk("sp_valid", s_val, 4'b1010);
    rd_sel = 2'd3; #1;
    chk("sp_rd3", {s_led, s_lc, s_lo}, {8'hCC, 1'b1, 1'b1});
    rd_sel = 2'd0; #1;
    chk("sp_rd0_untouched", {s_led, s_lc, s_lo}, 32'd0);

    // Empty mask
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    chk("em_cycle", {e_busy, e_done, e_op, e_val}, {24'd0, 1'b1, 1'b1, 2'd0, 4'd0});
    tick();
    chk("em_back_idle", {e_busy, e_done, e_op}, 32'd0);

    // Ignored inputs during DRIVE
    sw_x = 4'h3; sw_y = 4'hA; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 1) begin sw_x = 4'hF; sw_y = 4'hF; start_d = 1'b1; end
      tick();
      if (n == 1) start_d = 1'b0;
      chk($sformatf("ign_done_e%0d", n), d_done, (n == 12));
      if (n >= 13) chk($sformatf("ign_busy_e%0d", n), d_busy, 32'd0);
    end
    chk("ign_operands", {d_x, d_y}, {24'd0, 4'h3, 4'hA});
    rd_sel = 2'd0; #1;
    chk("ign_rd0", {d_led, d_lc, d_lo}, {8'h09, 1'b0, 1'b0});

    // Mid-sequence reset during opcode 2 CAPTURE
    sw_x = 4'b1001; sw_y = 4'b0101; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (8) tick();
    chk("mid_in_op2", {d_op, d_busy}, {29'd0, 2'd2, 1'b1});
    rst = 1'b1; #1;
    rd_sel = 2'd1; #1;
    chk("mid_rst_state", {d_busy, d_done, d_val, d_op, d_x, d_led}, 32'd0);
    repeat (2) begin
      tick();
      chk("mid_rst_no_done", d_done, 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("mid_post_idle", {d_busy, d_done}, 32'd0);
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("re_done_e%0d", n), d_done, (n == 12));
    end
    chk("re_valid", d_val, 4'b1111);
    chk("re_rd1", {d_led, d_lc, d_lo}, {8'h4C, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequencing controller for the 4-bit `simple_calc` datapath. On a start request it latches one operand pair from the switches, steps the calculator through every enabled operation code in ascending order, and waits a fixed settle time before capturing each result. Each result is stored in a per-opcode result register and can be read back to the LEDs by selector. It sits between the board switches/LEDs and the `simple_calc` instance, which it drives through its `CALC_*` ports.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the operands and opcode are held stable before capture; legal range 1–15.
- `OP_MASK`, default 4'b1111: bit n set means opcode n is executed in a sequence.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sequence request; sampled only in IDLE.
- `SW_X` in 4: operand X.
- `SW_Y` in 4: operand Y.
- `rd_sel` in 2: selects which stored result drives the LED outputs.
- `CALC_X` out 4: operand X to `simple_calc`.
- `CALC_Y` out 4: operand Y to `simple_calc`.
- `CALC_op_sel` out 2: opcode to `simple_calc`.
- `CALC_result` in 8: result from `simple_calc`.
- `CALC_carry_out` in 1: carry flag from `simple_calc`.
- `CALC_overflow` in 1: overflow flag from `simple_calc`.
- `LED_output_result` out 8: stored result for opcode `rd_sel`.
- `LED_carry_out` out 1: stored carry for opcode `rd_sel`.
- `LED_overflow` out 1: stored overflow for opcode `rd_sel`.
- `result_valid` out 4: bit n set when opcode n's entry was written by the most recent sequence.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse at the end of a sequence.

## Operation
- States: IDLE, DRIVE, CAPTURE, DONE.
- **IDLE, `start`=1 at an edge:**
  - Latch `SW_X`/`SW_Y` into `CALC_X`/`CALC_Y`.
  - Clear `result_valid`.
  - If `OP_MASK` is nonzero, set `CALC_op_sel` to the lowest set bit of `OP_MASK`, clear the settle counter, and go to DRIVE.
  - If `OP_MASK`=0, go directly to DONE.
- **DRIVE:** the counter increments each cycle. At the edge where counter = `SETTLE_CYCLES`-1, go to CAPTURE.
- **CAPTURE (one cycle):**
  - At its closing edge, write {`CALC_result`, `CALC_carry_out`, `CALC_overflow`} into entry[`CALC_op_sel`] and set `result_valid[CALC_op_sel]`.
  - If a higher enabled opcode exists, load it into `CALC_op_sel`, clear the counter, and go to DRIVE. Otherwise go to DONE.
- **DONE (one cycle):** `done`=1, then go to IDLE.
- **Operand and opcode stability:** `CALC_X`/`CALC_Y` change only on start acceptance. `CALC_op_sel` changes only on start acceptance or when leaving CAPTURE. All three hold their values in IDLE.
- **Ignored inputs:**
  - `start` in DRIVE, CAPTURE or DONE is ignored; no queuing.
  - Switch changes after acceptance have no effect.
- **Retained entries:** entries for opcodes disabled in `OP_MASK` keep their old contents but read as not valid.
- **Readback:** combinational from the entry registers by `rd_sel`, valid in any state. `rd_sel` has no effect on sequencing.

## Timing
- **Reset values** (asserting `rst` at any time, including mid-sequence):
  - State = IDLE.
  - `busy`=0, `done`=0, `result_valid`=0.
  - `CALC_X`=0, `CALC_Y`=0, `CALC_op_sel`=0.
  - All entries = 0, so `LED_output_result`=0, `LED_carry_out`=0, `LED_overflow`=0.
- **Mid-sequence reset:** a partially completed sequence is discarded with no `done` pulse. The first `start` after `rst` deasserts is accepted normally.
- **Per-opcode time:** `SETTLE_CYCLES`+1 cycles. The datapath input is stable for at least `SETTLE_CYCLES`+1 cycles before sampling.
- **Latency:** with k enabled opcodes, `done` is high in the cycle beginning k·(`SETTLE_CYCLES`+1) edges after the accepting edge. Defaults give 12 edges to `done` and 13 edges until IDLE.
- **`busy`:** rises with the accepting edge and falls with the edge that leaves DONE.
- **Back-to-back sequences:** `start` held high is accepted again the first cycle back in IDLE, one cycle after `done`.
- **`result_valid[n]`:** rises at the same edge that writes entry n.

## Test plan
The bench stub drives:
- `CALC_result` = {`CALC_op_sel`, 2'b00, `CALC_X` ^ `CALC_Y`}
- `CALC_carry_out` = `CALC_op_sel[0]`
- `CALC_overflow` = `CALC_op_sel[1]`

Scenarios:
- **Reset:** assert `rst` for 3 cycles. Require every output 0, then `busy`=0 and `done`=0 after release.
- **Full sequence, defaults:** `SW_X`=4'b1001, `SW_Y`=4'b0101, 1-cycle `start`.
  - `CALC_op_sel` steps 0,1,2,3, each held 3 cycles.
  - `done` pulses exactly 12 edges after acceptance; `result_valid`=4'b1111.
  - `rd_sel`=2 shows `LED_output_result`=8'h8C, `LED_carry_out`=0, `LED_overflow`=1.
  - `rd_sel`=1 shows 8'h4C, carry 1, overflow 0.
- **Sparse mask:** `OP_MASK`=4'b1010, `SETTLE_CYCLES`=3.
  - Only opcodes 1 and 3 are driven.
  - `done` pulses 8 edges after acceptance; `result_valid`=4'b1010.
- **Empty mask:** `OP_MASK`=0. `start` gives `busy` high 1 cycle with `done` in that cycle; `CALC_op_sel` stays 0.
- **Ignored inputs:** change `SW_X`/`SW_Y` and pulse `start` during DRIVE. Require `CALC_X`/`CALC_Y` unchanged, the sequence still 12 edges, and no second sequence.
- **Mid-sequence reset:** assert `rst` during opcode 2 CAPTURE. Require IDLE, `result_valid`=0, no `done` pulse, and a clean full sequence on the next `start`.
